addbit: RTL and testbench
=========================

// Module: addbit
// PURPOSE
//   1-bit full adder: s = a^b^cin, cout = majority(a,b,cin).
//   Combinational outputs serve ripple chains and gate-level benches.
//   A registered copy of the result (parameterised pipeline depth) and a saturating carry-out event counter serve clocked datapaths.
// PARAMETERS
//   PIPE_STAGES  1  register stages on s_q/cout_q/vld_q; legal 1..4
//   CNT_W        8  width of carry_cnt; legal 1..32
// PORTS
//   clk        in   1      rising-edge clock
//   rst        in   1      reset; asynchronous, active-high
//   cin        in   1      carry in
//   a          in   1      operand a
//   b          in   1      operand b
//   s          out  1      combinational sum
//   cout       out  1      combinational carry out
//   en         in   1      sample strobe for the registered path and counter
//   s_q        out  1      registered sum, PIPE_STAGES cycles after the en sample
//   cout_q     out  1      registered carry, aligned with s_q
//   vld_q      out  1      high when s_q/cout_q carry a sampled result
//   carry_cnt  out  CNT_W  count of en-samples with cout=1; saturating
//   g          out  1      generate a&b; present only with ADDBIT_GEN_PROP_EN
//   p          out  1      propagate a^b; present only with ADDBIT_GEN_PROP_EN
// BEHAVIOUR
//   - s and cout are purely combinational and independent of clk and rst:
//     - valid during reset and with clk stopped;
//     - settle within one delta of an input change;
//     - no latches.
//   - Truth table (cin,a,b -> s,cout):
//     000->00  100->10  001->10  101->01
//     010->10  110->01  011->01  111->11
//   - Reset: when rst asserts, immediately (async) clear every pipeline register:
//     - s_q=0, cout_q=0, vld_q=0, carry_cnt=0.
//     - Held at those values while rst is high.
//   - Pipeline:
//     - Stage 1 captures {s,cout,en} on each rising clk.
//     - Each further stage shifts by one.
//     - Outputs come from the last stage, so latency = PIPE_STAGES cycles.
//     - vld_q is the delayed en.
//     - s_q/cout_q update every cycle regardless of en; consumers qualify them with vld_q.
//   - Counter:
//     - On a rising clk with en=1 and cout=1, carry_cnt increments by 1.
//     - At 2^CNT_W-1 it holds (saturates); it never wraps.
//     - en=0 or cout=0 leaves it unchanged.
//   - Reset mid-operation:
//     - In-flight pipeline contents are discarded; vld_q drops in the same instant.
//     - After release, the first valid result appears PIPE_STAGES cycles after the first en sample.
//   - Reset release: sample on the first rising clk with rst low; no synchroniser inside the block.
//   - X on any input propagates to s/cout; registered outputs are not X-masked.
// CONFIGURATION
//   ADDBIT_GEN_PROP_EN defined:
//     - ports g and p exist, purely combinational: g=a&b, p=a^b.
//     - Invariants hold: s = p^cin, cout = g|(p&cin).
//   ADDBIT_GEN_PROP_EN undefined:
//     - g and p are absent from the port list.
//     - All other behaviour is identical.
// TESTING
//   - Exhaustive combinational check, no clock, rst=0:
//     - step {cin,a,b} through all 8 codes, 5 ns apart;
//     - s/cout match the truth table after each step.
//   - rst=1 with inputs 111:
//     - s=1, cout=1 still;
//     - s_q=0, cout_q=0, vld_q=0, carry_cnt=0 asynchronously, without a clk edge.
//   - PIPE_STAGES=2, en=1 for one cycle with inputs 011:
//     - vld_q=1, s_q=0, cout_q=1 exactly 2 cycles later;
//     - vld_q=0 the following cycle.
//   - CNT_W=2, en=1 with inputs 110 for 5 cycles:
//     - carry_cnt goes 1,2,3,3,3 (saturates);
//     - inputs 100 with en=1 leave it at 3.
//   - Assert rst while vld_q=1:
//     - vld_q and carry_cnt clear at once;
//     - after release, en with inputs 101 gives vld_q=1, cout_q=1 after PIPE_STAGES cycles.
//   - With ADDBIT_GEN_PROP_EN: inputs a=1, b=1 -> g=1, p=0; a=1, b=0 -> g=0, p=1.

Source files
------------

// File: rtl/addbit.sv
// 1-bit full adder with a registered result pipeline and a saturating carry-out counter.
// Define ADDBIT_GEN_PROP_EN to expose the generate/propagate terms as ports g and p.
module addbit #(
  parameter int PIPE_STAGES = 1,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cin,
  input  logic             a,
  input  logic             b,
  output logic             s,
  output logic             cout,
  input  logic             en,
  output logic             s_q,
  output logic             cout_q,
  output logic             vld_q,
  output logic [CNT_W-1:0] carry_cnt
`ifdef ADDBIT_GEN_PROP_EN
  ,
  output logic             g,
  output logic             p
`endif
);

  logic gen_t;
  logic prop_t;

  assign gen_t  = a & b;
  assign prop_t = a ^ b;
  assign s      = prop_t ^ cin;
  assign cout   = gen_t | (prop_t & cin);

`ifdef ADDBIT_GEN_PROP_EN
  assign g = gen_t;
  assign p = prop_t;
`endif

  // Index 0 is the first stage; the last index drives the outputs.
  logic [PIPE_STAGES-1:0] s_pipe;
  logic [PIPE_STAGES-1:0] cout_pipe;
  logic [PIPE_STAGES-1:0] vld_pipe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_pipe    <= '0;
      cout_pipe <= '0;
      vld_pipe  <= '0;
    end else begin
      s_pipe[0]    <= s;
      cout_pipe[0] <= cout;
      vld_pipe[0]  <= en;
      for (int i = 1; i < PIPE_STAGES; i++) begin
        s_pipe[i]    <= s_pipe[i-1];
        cout_pipe[i] <= cout_pipe[i-1];
        vld_pipe[i]  <= vld_pipe[i-1];
      end
    end
  end

  assign s_q    = s_pipe[PIPE_STAGES-1];
  assign cout_q = cout_pipe[PIPE_STAGES-1];
  assign vld_q  = vld_pipe[PIPE_STAGES-1];

  // Holds at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carry_cnt <= '0;
    end else if (en && cout && (carry_cnt != {CNT_W{1'b1}})) begin
      carry_cnt <= carry_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_addbit.sv
// Self-checking bench for addbit: truth table, async reset, pipeline latency,
// counter saturation, mid-operation reset and randomized traffic against a model.
module tb_addbit;

  localparam int PS = 2;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          clk_run = 1'b0;
  logic          rst = 1'b0;
  logic          cin = 1'b0;
  logic          a = 1'b0;
  logic          b = 1'b0;
  logic          en = 1'b0;
  logic          s;
  logic          cout;
  logic          s_q;
  logic          cout_q;
  logic          vld_q;
  logic [CW-1:0] carry_cnt;
`ifdef ADDBIT_GEN_PROP_EN
  logic          g;
  logic          p;
`endif

  int n_vec  = 0;
  int n_fail = 0;

  // Expected {s, cout, vld} history, one entry per rising edge.
  logic [2:0] exp_q[$];
  int         exp_cnt;

  addbit #(.PIPE_STAGES(PS), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .cin       (cin),
    .a         (a),
    .b         (b),
    .s         (s),
    .cout      (cout),
    .en        (en),
    .s_q       (s_q),
    .cout_q    (cout_q),
    .vld_q     (vld_q),
    .carry_cnt (carry_cnt)
`ifdef ADDBIT_GEN_PROP_EN
    ,
    .g         (g),
    .p         (p)
`endif
  );

  always #5 if (clk_run) clk = ~clk;

  // Drive one sample before a rising edge, return 1 ns after it.
  task automatic cycle(input logic e, input logic c, input logic x, input logic y);
    @(negedge clk);
    en  = e;
    cin = c;
    a   = x;
    b   = y;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    en  = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_comb();
    logic [2:0] code;
    int         sum;
    for (int i = 0; i < 8; i++) begin
      code = 3'(i);
      {cin, a, b} = code;
      #5;
      sum = int'(code[2]) + int'(code[1]) + int'(code[0]);
      n_vec++;
      if ({s, cout} !== {logic'(sum % 2), logic'(sum >= 2)}) begin
        n_fail++;
        $display("FAIL comb code=%b got s,cout=%b%b want %0d%0d", code, s, cout, sum % 2, sum >= 2);
      end
    end
  endtask

  task automatic test_reset();
    {cin, a, b} = 3'b111;
    rst = 1'b1;
    #1;
    n_vec++;
    if ({s, cout} !== 2'b11) begin
      n_fail++;
      $display("FAIL reset_comb got s,cout=%b%b want 11", s, cout);
    end
    n_vec++;
    if ({s_q, cout_q, vld_q} !== 3'b000 || carry_cnt !== '0) begin
      n_fail++;
      $display("FAIL reset_regs got s_q,cout_q,vld_q=%b%b%b cnt=%0d want 000 cnt=0",
               s_q, cout_q, vld_q, carry_cnt);
    end
    clk_run = 1'b1;
    #13;
    rst = 1'b0;
  endtask

  task automatic test_latency();
    do_reset();
    cycle(1'b1, 1'b0, 1'b1, 1'b1);
    n_vec++;
    if (vld_q !== 1'b0) begin
      n_fail++;
      $display("FAIL lat_early got vld_q=%b want 0", vld_q);
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if ({vld_q, s_q, cout_q} !== 3'b101) begin
      n_fail++;
      $display("FAIL lat_out got vld,s_q,cout_q=%b%b%b want 101", vld_q, s_q, cout_q);
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if (vld_q !== 1'b0) begin
      n_fail++;
      $display("FAIL lat_drop got vld_q=%b want 0", vld_q);
    end
  endtask

  task automatic test_saturate();
    int want;
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      cycle(1'b1, 1'b1, 1'b1, 1'b0);
      want = (i > 3) ? 3 : i;
      n_vec++;
      if (carry_cnt !== CW'(want)) begin
        n_fail++;
        $display("FAIL sat_step%0d got cnt=%0d want %0d", i, carry_cnt, want);
      end
    end
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 1'b0);
      n_vec++;
      if (carry_cnt !== CW'(3)) begin
        n_fail++;
        $display("FAIL sat_nocarry got cnt=%0d want 3", carry_cnt);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    n_vec++;
    if (vld_q !== 1'b1 || carry_cnt !== CW'(2)) begin
      n_fail++;
      $display("FAIL mid_pre got vld_q=%b cnt=%0d want 1 cnt=2", vld_q, carry_cnt);
    end
    #2;
    rst = 1'b1;
    #1;
    n_vec++;
    if (vld_q !== 1'b0 || carry_cnt !== '0) begin
      n_fail++;
      $display("FAIL mid_clear got vld_q=%b cnt=%0d want 0 cnt=0", vld_q, carry_cnt);
    end
    en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    n_vec++;
    if (vld_q !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_early got vld_q=%b want 0", vld_q);
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if ({vld_q, s_q, cout_q} !== 3'b101) begin
      n_fail++;
      $display("FAIL mid_after got vld,s_q,cout_q=%b%b%b want 101", vld_q, s_q, cout_q);
    end
  endtask

  task automatic test_random();
    logic       e, c, x, y;
    logic [2:0] want;
    int         t;
    do_reset();
    exp_q.delete();
    for (int i = 0; i < PS - 1; i++) exp_q.push_back(3'b000);
    exp_cnt = 0;
    for (int i = 0; i < 300; i++) begin
      e = 1'($urandom_range(0, 1));
      c = 1'($urandom_range(0, 1));
      x = 1'($urandom_range(0, 1));
      y = 1'($urandom_range(0, 1));
      cycle(e, c, x, y);
      t = int'(c) + int'(x) + int'(y);
      exp_q.push_back({logic'(t % 2), logic'(t >= 2), e});
      if (e && t >= 2 && exp_cnt < (1 << CW) - 1) exp_cnt++;
      want = exp_q.pop_front();
      n_vec++;
      if ({s_q, cout_q, vld_q} !== want || carry_cnt !== CW'(exp_cnt)) begin
        n_fail++;
        $display("FAIL rand%0d got s_q,cout_q,vld=%b%b%b cnt=%0d want %b cnt=%0d",
                 i, s_q, cout_q, vld_q, carry_cnt, want, exp_cnt);
      end
      n_vec++;
      if ({s, cout} !== {logic'(t % 2), logic'(t >= 2)}) begin
        n_fail++;
        $display("FAIL rand_comb%0d got s,cout=%b%b want %0d%0d", i, s, cout, t % 2, t >= 2);
      end
    end
  endtask

`ifdef ADDBIT_GEN_PROP_EN
  task automatic test_gen_prop();
    {cin, a, b} = 3'b011;
    #1;
    n_vec++;
    if ({g, p} !== 2'b10) begin
      n_fail++;
      $display("FAIL gp_11 got g,p=%b%b want 10", g, p);
    end
    {cin, a, b} = 3'b010;
    #1;
    n_vec++;
    if ({g, p} !== 2'b01) begin
      n_fail++;
      $display("FAIL gp_10 got g,p=%b%b want 01", g, p);
    end
  endtask
`endif

  initial begin
    test_comb();
`ifdef ADDBIT_GEN_PROP_EN
    test_gen_prop();
`endif
    test_reset();
    test_latency();
    test_saturate();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule
